// File: rtl/hfsm_pkg.sv
// Shared definitions for the hierarchical sequencing FSM.
// Used by the next-state logic, the current-state register and the output
// decode, so every block agrees on the state encoding.
package hfsm_pkg;

  localparam int STATE_W = 3;

  // S0 idle, S1..S3 group A, S4..S6 group B (looped), S7 done
  typedef enum logic [STATE_W-1:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5,
    S6 = 3'd6,
    S7 = 3'd7
  } state_e;

  // Sequential successor inside the linear part of the walk (S1..S5)
  function automatic state_e state_succ(input state_e s);
    logic [STATE_W-1:0] raw;
    raw = s;
    return state_e'(raw + 3'd1);
  endfunction

endpackage

// File: rtl/hfsm_dwell_counter.sv
// Saturating dwell counter for the hierarchical FSM.
// clr has priority over hold, hold over inc; with none asserted the count
// is kept. at_term flags that the count equals the supplied terminal value.
module hfsm_dwell_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             hold,
  input  logic             inc,
  input  logic [CNT_W-1:0] term_val,
  output logic [CNT_W-1:0] cnt,
  output logic             at_term
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Count register: clear, freeze or advance, never wrapping past all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (hold) begin
      cnt <= cnt;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_term = (cnt == term_val);

endmodule

// File: rtl/hfsm_next_state_logic.sv
// Next-state logic of the hierarchical sequencing FSM.
// Top level walks IDLE -> group A (S1..S3) -> group B (S4..S6, ROUNDS
// passes) -> DONE (S7) -> IDLE. Each state is held for a dwell time tracked
// by hfsm_dwell_counter; round_cnt counts completed group-B passes.
// next_state is purely combinational and feeds an external state register;
// dwell_cnt, round_cnt and done are registered here.
// Build option HFSM_AUTO_RESTART_EN: when defined, a held start at the end
// of S7 jumps straight to S1 instead of passing through S0.
module hfsm_next_state_logic
  import hfsm_pkg::*;
#(
  parameter int PHASE_DWELL = 4,
  parameter int HOLD_DWELL  = 2,
  parameter int ROUNDS      = 2,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       current_state,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  output logic [2:0]       next_state,
  output logic [CNT_W-1:0] dwell_cnt,
  output logic [2:0]       round_cnt,
  output logic             done
);

  // Terminal dwell counts: a state is left on its last counted cycle
  localparam logic [CNT_W-1:0] PHASE_TERM = CNT_W'(PHASE_DWELL - 1);
  localparam logic [CNT_W-1:0] HOLD_TERM  = CNT_W'(HOLD_DWELL - 1);
  localparam logic [2:0]       ROUND_LAST = 3'(ROUNDS - 1);
  localparam logic [2:0]       ROUND_MAX  = 3'd7;

  state_e           cur_s;
  state_e           nxt_s;
  logic             dwell_at_term;
  logic             dwell_clr;
  logic             dwell_inc;
  logic [CNT_W-1:0] dwell_term;
  logic             last_round;
  logic             state_change;

  assign cur_s        = state_e'(current_state);
  assign last_round   = (round_cnt == ROUND_LAST);
  assign state_change = (nxt_s != cur_s);

  // S7 uses the shorter hold time, every other timed state the phase time
  assign dwell_term = (cur_s == S7) ? HOLD_TERM : PHASE_TERM;

  // Any state change or abort restarts the dwell count; idle parks it at 0
  // unless paused, in which case it is simply frozen.
  assign dwell_clr = abort | state_change | ((cur_s == S0) & ~pause);
  assign dwell_inc = (cur_s != S0);

  hfsm_dwell_counter #(
    .CNT_W(CNT_W)
  ) u_dwell (
    .clk     (clk),
    .rst     (rst),
    .clr     (dwell_clr),
    .hold    (pause),
    .inc     (dwell_inc),
    .term_val(dwell_term),
    .cnt     (dwell_cnt),
    .at_term (dwell_at_term)
  );

  // Next-state decode: abort beats pause, pause beats normal sequencing
  always_comb begin
    nxt_s = cur_s;
    if (abort) begin
      nxt_s = S0;
    end else if (!pause) begin
      case (cur_s)
        S0: begin
          if (start) nxt_s = S1;
        end
        S1, S2, S3, S4, S5: begin
          if (dwell_at_term) nxt_s = state_succ(cur_s);
        end
        S6: begin
          if (dwell_at_term) nxt_s = last_round ? S7 : S4;
        end
        S7: begin
          if (dwell_at_term) begin
`ifdef HFSM_AUTO_RESTART_EN
            nxt_s = start ? S1 : S0;
`else
            nxt_s = S0;
`endif
          end
        end
        default: nxt_s = S0;
      endcase
    end
  end

  assign next_state = nxt_s;

  // Group-B pass counter: cleared when idle, on abort and when leaving the
  // loop for S7; advanced on each S6 -> S4 loop-back, saturating at 7.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      round_cnt <= 3'd0;
    end else if (abort || (cur_s == S0) || ((cur_s == S6) && (nxt_s == S7))) begin
      round_cnt <= 3'd0;
    end else if ((cur_s == S6) && (nxt_s == S4) && (round_cnt != ROUND_MAX)) begin
      round_cnt <= round_cnt + 3'd1;
    end
  end

  // Done pulse: registered alongside the state register so it lines up
  // with the first cycle spent in S7.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done <= 1'b0;
    end else begin
      done <= (nxt_s == S7) && (cur_s != S7) && !abort;
    end
  end

endmodule

// File: tb/tb_hfsm_next_state_logic.sv
// Directed bench for hfsm_next_state_logic. Two instances: dut_a with the
// default parameters and dut_b with PHASE_DWELL=1, ROUNDS=1. Each has a
// local current-state register closing the loop, reset by the same rst.
module tb_hfsm_next_state_logic;
  import hfsm_pkg::*;

  logic       clk;
  logic       rst;

  logic [2:0] cs_a, ns_a, round_a;
  logic [3:0] dwell_a;
  logic       start_a, pause_a, abort_a, done_a;

  logic [2:0] cs_b, ns_b, round_b;
  logic [3:0] dwell_b;
  logic       start_b, pause_b, abort_b, done_b;

  int n_cmp;
  int n_fail;

  hfsm_next_state_logic dut_a (
    .clk          (clk),
    .rst          (rst),
    .current_state(cs_a),
    .start        (start_a),
    .pause        (pause_a),
    .abort        (abort_a),
    .next_state   (ns_a),
    .dwell_cnt    (dwell_a),
    .round_cnt    (round_a),
    .done         (done_a)
  );

  hfsm_next_state_logic #(
    .PHASE_DWELL(1),
    .HOLD_DWELL (2),
    .ROUNDS     (1),
    .CNT_W      (4)
  ) dut_b (
    .clk          (clk),
    .rst          (rst),
    .current_state(cs_b),
    .start        (start_b),
    .pause        (pause_b),
    .abort        (abort_b),
    .next_state   (ns_b),
    .dwell_cnt    (dwell_b),
    .round_cnt    (round_b),
    .done         (done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cs_a <= 3'd0;
    else     cs_a <= ns_a;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) cs_b <= 3'd0;
    else     cs_b <= ns_b;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    n_cmp++; if (dwell_a !== 4'd0) begin n_fail++; $display("FAIL reset_dwell: got %0d want 0", dwell_a); end
    n_cmp++; if (round_a !== 3'd0) begin n_fail++; $display("FAIL reset_round: got %0d want 0", round_a); end
    n_cmp++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0d want 0", done_a); end
    n_cmp++; if (ns_a !== S0) begin n_fail++; $display("FAIL reset_next: got %0d want 0", ns_a); end
    tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (cs_a !== S0) begin n_fail++; $display("FAIL reset_idle_state: got %0d want 0", cs_a); end
    n_cmp++; if (dwell_a !== 4'd0) begin n_fail++; $display("FAIL reset_idle_dwell: got %0d want 0", dwell_a); end
  endtask

  task automatic test_full_sequence;
    int n;
    int pulses;
    logic [2:0] last_round;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    n_cmp++; if (cs_a !== S1) begin n_fail++; $display("FAIL seq_s1_entry: got %0d want 1", cs_a); end
    n_cmp++; if (dwell_a !== 4'd0) begin n_fail++; $display("FAIL seq_s1_dwell: got %0d want 0", dwell_a); end
    n = 0;
    pulses = 0;
    last_round = 3'd0;
    while (cs_a != S7 && n < 100) begin
      last_round = round_a;
      tick();
      n++;
      if (done_a) pulses++;
    end
    n_cmp++; if (n !== 36) begin n_fail++; $display("FAIL seq_s7_latency: got %0d want 36", n); end
    n_cmp++; if (done_a !== 1'b1) begin n_fail++; $display("FAIL seq_done_on_entry: got %0d want 1", done_a); end
    n_cmp++; if (last_round !== 3'd1) begin n_fail++; $display("FAIL seq_round_before_s7: got %0d want 1", last_round); end
    n_cmp++; if (round_a !== 3'd0) begin n_fail++; $display("FAIL seq_round_in_s7: got %0d want 0", round_a); end
    tick();
    n_cmp++; if (cs_a !== S7) begin n_fail++; $display("FAIL seq_s7_hold: got %0d want 7", cs_a); end
    n_cmp++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL seq_done_width: got %0d want 0", done_a); end
    tick();
    n_cmp++; if (cs_a !== S0) begin n_fail++; $display("FAIL seq_back_to_idle: got %0d want 0", cs_a); end
    n_cmp++; if (pulses !== 1) begin n_fail++; $display("FAIL seq_done_count: got %0d want 1", pulses); end
  endtask

  task automatic test_pause;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (4) tick();
    n_cmp++; if (cs_a !== S2) begin n_fail++; $display("FAIL pause_reach_s2: got %0d want 2", cs_a); end
    repeat (3) tick();
    n_cmp++; if (dwell_a !== 4'd3) begin n_fail++; $display("FAIL pause_pre_dwell: got %0d want 3", dwell_a); end
    pause_a = 1'b1;
    #1;
    n_cmp++; if (ns_a !== S2) begin n_fail++; $display("FAIL pause_suppress: got %0d want 2", ns_a); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (cs_a !== S2) begin n_fail++; $display("FAIL pause_state_%0d: got %0d want 2", i, cs_a); end
      n_cmp++; if (dwell_a !== 4'd3) begin n_fail++; $display("FAIL pause_dwell_%0d: got %0d want 3", i, dwell_a); end
    end
    pause_a = 1'b0;
    #1;
    n_cmp++; if (ns_a !== S3) begin n_fail++; $display("FAIL pause_release_next: got %0d want 3", ns_a); end
    tick();
    n_cmp++; if (cs_a !== S3) begin n_fail++; $display("FAIL pause_s3_entry: got %0d want 3", cs_a); end
    n_cmp++; if (dwell_a !== 4'd0) begin n_fail++; $display("FAIL pause_s3_dwell: got %0d want 0", dwell_a); end
  endtask

  task automatic test_abort;
    int n;
    n = 0;
    while (!(cs_a == S5 && round_a == 3'd1) && n < 200) begin
      tick();
      n++;
    end
    n_cmp++; if (n >= 200) begin n_fail++; $display("FAIL abort_reach_s5: got timeout after %0d cycles want S5 round 1", n); end
    abort_a = 1'b1;
    #1;
    n_cmp++; if (ns_a !== S0) begin n_fail++; $display("FAIL abort_next: got %0d want 0", ns_a); end
    tick();
    abort_a = 1'b0;
    n_cmp++; if (cs_a !== S0) begin n_fail++; $display("FAIL abort_state: got %0d want 0", cs_a); end
    n_cmp++; if (dwell_a !== 4'd0) begin n_fail++; $display("FAIL abort_dwell: got %0d want 0", dwell_a); end
    n_cmp++; if (round_a !== 3'd0) begin n_fail++; $display("FAIL abort_round: got %0d want 0", round_a); end
    n_cmp++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %0d want 0", done_a); end
    tick();
    n_cmp++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL abort_done_late: got %0d want 0", done_a); end
  endtask

  task automatic test_abort_start;
    abort_a = 1'b1;
    start_a = 1'b1;
    #1;
    n_cmp++; if (ns_a !== S0) begin n_fail++; $display("FAIL abort_start_next: got %0d want 0", ns_a); end
    tick();
    n_cmp++; if (cs_a !== S0) begin n_fail++; $display("FAIL abort_start_state: got %0d want 0", cs_a); end
    abort_a = 1'b0;
    start_a = 1'b0;
    tick();
  endtask

  task automatic test_short_config;
    state_e exp_b [9];
    int s4_visits;
    exp_b = '{S1, S2, S3, S4, S5, S6, S7, S7, S0};
    s4_visits = 0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int i = 0; i < 9; i++) begin
      n_cmp++; if (cs_b !== exp_b[i]) begin n_fail++; $display("FAIL short_state_%0d: got %0d want %0d", i, cs_b, exp_b[i]); end
      if (cs_b == S4) s4_visits++;
      if (i == 6) begin
        n_cmp++; if (done_b !== 1'b1) begin n_fail++; $display("FAIL short_done: got %0d want 1", done_b); end
      end
      if (i == 7) begin
        n_cmp++; if (done_b !== 1'b0) begin n_fail++; $display("FAIL short_done_width: got %0d want 0", done_b); end
      end
      tick();
    end
    n_cmp++; if (s4_visits !== 1) begin n_fail++; $display("FAIL short_s4_visits: got %0d want 1", s4_visits); end
  endtask

  task automatic test_async_reset;
    int n;
    int pulses;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    n = 0;
    while (!(cs_a == S6 && round_a == 3'd1 && dwell_a == 4'd3) && n < 200) begin
      tick();
      n++;
    end
    n_cmp++; if (n >= 200) begin n_fail++; $display("FAIL areset_reach_s6: got timeout after %0d cycles want S6 last cycle", n); end
    n_cmp++; if (ns_a !== S7) begin n_fail++; $display("FAIL areset_pending: got %0d want 7", ns_a); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (dwell_a !== 4'd0) begin n_fail++; $display("FAIL areset_dwell: got %0d want 0", dwell_a); end
    n_cmp++; if (round_a !== 3'd0) begin n_fail++; $display("FAIL areset_round: got %0d want 0", round_a); end
    n_cmp++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL areset_done: got %0d want 0", done_a); end
    n_cmp++; if (cs_a !== S0) begin n_fail++; $display("FAIL areset_state: got %0d want 0", cs_a); end
    tick();
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done_a) pulses++;
    end
    n_cmp++; if (cs_a !== S0) begin n_fail++; $display("FAIL areset_stay_idle: got %0d want 0", cs_a); end
    n_cmp++; if (pulses !== 0) begin n_fail++; $display("FAIL areset_no_done: got %0d want 0", pulses); end
  endtask

  task automatic test_auto_restart;
    int n;
    start_a = 1'b1;
    tick();
    n = 0;
    while (cs_a != S7 && n < 100) begin
      tick();
      n++;
    end
    n_cmp++; if (n >= 100) begin n_fail++; $display("FAIL restart_reach_s7: got timeout after %0d cycles want S7", n); end
    tick();
`ifdef HFSM_AUTO_RESTART_EN
    n_cmp++; if (ns_a !== S1) begin n_fail++; $display("FAIL restart_next: got %0d want 1", ns_a); end
    tick();
    n_cmp++; if (cs_a !== S1) begin n_fail++; $display("FAIL restart_state: got %0d want 1", cs_a); end
    n_cmp++; if (round_a !== 3'd0) begin n_fail++; $display("FAIL restart_round: got %0d want 0", round_a); end
    n_cmp++; if (dwell_a !== 4'd0) begin n_fail++; $display("FAIL restart_dwell: got %0d want 0", dwell_a); end
`else
    n_cmp++; if (ns_a !== S0) begin n_fail++; $display("FAIL restart_next: got %0d want 0", ns_a); end
    tick();
    n_cmp++; if (cs_a !== S0) begin n_fail++; $display("FAIL restart_idle: got %0d want 0", cs_a); end
    tick();
    n_cmp++; if (cs_a !== S1) begin n_fail++; $display("FAIL restart_state: got %0d want 1", cs_a); end
`endif
    start_a = 1'b0;
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    tick();
  endtask

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    rst     = 1'b0;
    start_a = 1'b0;
    pause_a = 1'b0;
    abort_a = 1'b0;
    start_b = 1'b0;
    pause_b = 1'b0;
    abort_b = 1'b0;
    #2;
    test_reset();
    test_full_sequence();
    test_pause();
    test_abort();
    test_abort_start();
    test_short_config();
    test_async_reset();
    test_auto_restart();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
